// File: rtl/vdf_pkg.sv
// Shared types for the VDF iteration sequencer: FSM states and iteration-count type.
package vdf_pkg;

  localparam int unsigned IterWDefault = 64;

  typedef logic [IterWDefault-1:0] iter_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/vdf_iter_counter.sv
// Iteration counter with terminal-count compare; optional checkpoint detect (VDF_CHECKPOINT_EN).
module vdf_iter_counter
  import vdf_pkg::*;
#(
  parameter int unsigned ITER_W = IterWDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [ITER_W-1:0] t_i,
`ifdef VDF_CHECKPOINT_EN
  input  logic [ITER_W-1:0] interval_i,
  output logic              ckpt_hit_o,
`endif
  output logic [ITER_W-1:0] count_o,
  output logic              last_o
);

  logic [ITER_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + ITER_W'(1);
    end
  end

  assign count_o = count_q;
  // Only evaluated in RUN, where T is known to be nonzero.
  assign last_o  = (count_q == (t_i - ITER_W'(1)));

`ifdef VDF_CHECKPOINT_EN
  logic [ITER_W-1:0] interval_q;
  logic [ITER_W-1:0] down_q;

  // Down-counter reloaded with the interval replaces a modulo check on count_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      interval_q <= '0;
      down_q     <= '0;
    end else if (clear_i) begin
      interval_q <= interval_i;
      down_q     <= interval_i;
    end else if (inc_i) begin
      down_q <= (down_q == ITER_W'(1)) ? interval_q : down_q - ITER_W'(1);
    end
  end

  assign ckpt_hit_o = inc_i && (interval_q != '0) && (down_q == ITER_W'(1));
`endif

endmodule

// File: rtl/vdf_iteration_sequencer.sv
// Job-level controller for the modular squarer: y = x^(2^T) mod N.
// Optional checkpoint outputs are enabled with VDF_CHECKPOINT_EN.
module vdf_iteration_sequencer
  import vdf_pkg::*;
#(
  parameter int unsigned MOD_LEN = 1024,
  parameter int unsigned ITER_W  = IterWDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               job_valid_i,
  output logic               job_ready_o,
  input  logic [MOD_LEN-1:0] job_x_i,
  input  logic [ITER_W-1:0]  job_t_i,
  input  logic               abort_i,
  output logic               sq_start_o,
  output logic [MOD_LEN-1:0] sq_in_o,
  input  logic               sq_valid_i,
  input  logic [MOD_LEN-1:0] sq_out_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [MOD_LEN-1:0] res_data_o,
`ifdef VDF_CHECKPOINT_EN
  input  logic [ITER_W-1:0]  ckpt_interval_i,
  output logic               ckpt_valid_o,
  output logic [MOD_LEN-1:0] ckpt_data_o,
`endif
  output logic               busy_o,
  output logic [ITER_W-1:0]  iter_done_o
);

  seq_state_e         state_q;
  logic               job_ready_q;
  logic               sq_start_q;
  logic               res_valid_q;
  logic [MOD_LEN-1:0] sq_in_q;
  logic [MOD_LEN-1:0] res_data_q;
  logic [ITER_W-1:0]  t_q;

  logic accept;
  logic inc;
  logic last;

  assign accept = (state_q == StIdle) && job_valid_i && job_ready_q;
  assign inc    = (state_q == StRun) && sq_valid_i && !abort_i;

`ifdef VDF_CHECKPOINT_EN
  logic               ckpt_hit;
  logic               ckpt_valid_q;
  logic [MOD_LEN-1:0] ckpt_data_q;
`endif

  vdf_iter_counter #(
    .ITER_W(ITER_W)
  ) u_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (accept),
    .inc_i     (inc),
    .t_i       (t_q),
`ifdef VDF_CHECKPOINT_EN
    .interval_i(ckpt_interval_i),
    .ckpt_hit_o(ckpt_hit),
`endif
    .count_o   (iter_done_o),
    .last_o    (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      job_ready_q <= 1'b0;
      sq_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      sq_in_q     <= '0;
      res_data_q  <= '0;
      t_q         <= '0;
    end else begin
      sq_start_q <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q     <= StIdle;
        res_valid_q <= 1'b0;
        job_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            job_ready_q <= 1'b1;
            if (accept) begin
              job_ready_q <= 1'b0;
              sq_in_q     <= job_x_i;
              t_q         <= job_t_i;
              if (job_t_i == '0) begin
                res_data_q  <= job_x_i;
                res_valid_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                sq_start_q <= 1'b1;
                state_q    <= StStart;
              end
            end
          end
          StStart: state_q <= StRun;
          StRun: begin
            if (sq_valid_i && last) begin
              res_data_q  <= sq_out_i;
              res_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
          StDone: begin
            if (res_ready_i) begin
              res_valid_q <= 1'b0;
              job_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef VDF_CHECKPOINT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ckpt_valid_q <= 1'b0;
      ckpt_data_q  <= '0;
    end else begin
      ckpt_valid_q <= ckpt_hit;
      if (ckpt_hit) begin
        ckpt_data_q <= sq_out_i;
      end
    end
  end

  assign ckpt_valid_o = ckpt_valid_q;
  assign ckpt_data_o  = ckpt_data_q;
`endif

  assign job_ready_o = job_ready_q;
  assign sq_start_o  = sq_start_q;
  assign sq_in_o     = sq_in_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_vdf_iteration_sequencer.sv
// Directed bench for vdf_iteration_sequencer with a 10-cycle mod-65521 squarer model.
module tb_vdf_iteration_sequencer;

  localparam int unsigned MOD_LEN = 16;
  localparam int unsigned ITER_W  = 64;
  localparam longint unsigned NMOD = 65521;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               job_valid;
  logic               job_ready;
  logic [MOD_LEN-1:0] job_x;
  logic [ITER_W-1:0]  job_t;
  logic               abort;
  logic               sq_start;
  logic [MOD_LEN-1:0] sq_in;
  logic               sq_valid = 1'b0;
  logic [MOD_LEN-1:0] sq_out = '0;
  logic               res_valid;
  logic               res_ready;
  logic [MOD_LEN-1:0] res_data;
  logic               busy;
  logic [ITER_W-1:0]  iter_done;
`ifdef VDF_CHECKPOINT_EN
  logic [ITER_W-1:0]  ckpt_interval;
  logic               ckpt_valid;
  logic [MOD_LEN-1:0] ckpt_data;
  int                 ck_n;
  logic [MOD_LEN-1:0] ck_data [0:3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vdf_iteration_sequencer #(
    .MOD_LEN(MOD_LEN),
    .ITER_W (ITER_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .job_valid_i    (job_valid),
    .job_ready_o    (job_ready),
    .job_x_i        (job_x),
    .job_t_i        (job_t),
    .abort_i        (abort),
    .sq_start_o     (sq_start),
    .sq_in_o        (sq_in),
    .sq_valid_i     (sq_valid),
    .sq_out_i       (sq_out),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
`ifdef VDF_CHECKPOINT_EN
    .ckpt_interval_i(ckpt_interval),
    .ckpt_valid_o   (ckpt_valid),
    .ckpt_data_o    (ckpt_data),
`endif
    .busy_o         (busy),
    .iter_done_o    (iter_done)
  );

  // Free-running squarer: restarts on sq_start, pulses every 10 cycles, never stops.
  logic [MOD_LEN-1:0] sq_val = '0;
  int                 sq_cnt = 0;
  logic               sq_run = 1'b0;

  function automatic logic [MOD_LEN-1:0] sqr(input logic [MOD_LEN-1:0] v);
    longint unsigned p;
    p = longint'(v) * longint'(v);
    return MOD_LEN'(p % NMOD);
  endfunction

  always @(posedge clk) begin
    if (sq_start) begin
      sq_val   <= sq_in;
      sq_cnt   <= 0;
      sq_run   <= 1'b1;
      sq_valid <= 1'b0;
      sq_out   <= 16'hDEAD;
    end else if (sq_run) begin
      if (sq_cnt == 9) begin
        sq_cnt   <= 0;
        sq_valid <= 1'b1;
        sq_out   <= sqr(sq_val);
        sq_val   <= sqr(sq_val);
      end else begin
        sq_cnt   <= sq_cnt + 1;
        sq_valid <= 1'b0;
        sq_out   <= 16'hDEAD;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer a job at a negedge; returns two negedges later, after any squarer restart.
  task automatic send_job(input logic [MOD_LEN-1:0] x, input logic [ITER_W-1:0] t,
                          output logic start_seen, output logic rv_next);
    job_x     = x;
    job_t     = t;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid  = 1'b0;
    start_seen = sq_start;
    rv_next    = res_valid;
    @(negedge clk);
  endtask

  task automatic wait_result(input int budget, output int starts, output int valids,
                             output int lat, output logic got);
    int last_i;
    starts = 0;
    valids = 0;
    lat    = -1;
    got    = 1'b0;
    last_i = -100;
`ifdef VDF_CHECKPOINT_EN
    ck_n = 0;
`endif
    for (int i = 0; i < budget; i++) begin
`ifdef VDF_CHECKPOINT_EN
      if (ckpt_valid) begin
        if (ck_n < 4) ck_data[ck_n] = ckpt_data;
        ck_n++;
      end
`endif
      if (sq_start) starts++;
      if (res_valid) begin
        got = 1'b1;
        lat = i - last_i;
        break;
      end
      if (sq_valid) begin
        valids++;
        last_i = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valids(input int n, input int budget, output logic ok);
    int cnt;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sq_valid) cnt++;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check(tag, busy, 0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_job_ready"}, job_ready, 0);
    check({tag, "_sq_start"}, sq_start, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_iter_done"}, iter_done, 0);
    check({tag, "_sq_in"}, sq_in, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  initial begin
    logic s, r, got, ok, seen;
    int   starts, valids, lat;

    rst_n     = 1'b0;
    job_valid = 1'b0;
    job_x     = '0;
    job_t     = '0;
    abort     = 1'b0;
    res_ready = 1'b0;
`ifdef VDF_CHECKPOINT_EN
    ckpt_interval = '0;
`endif
    repeat (3) @(negedge clk);
    reset_outputs("rst");
    rst_n = 1'b1;
    check("ready_at_release", job_ready, 0);
    @(negedge clk);
    check("ready_after_release", job_ready, 1);

    // Abort while idle must be a no-op.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", job_ready, 1);
    check("idle_abort_busy", busy, 0);

    // Basic x=3, T=4.
    send_job(16'd3, 64'd4, s, r);
    check("basic_start", s, 1);
    wait_result(100, starts, valids, lat, got);
    check("basic_got", got, 1);
    check("basic_extra_starts", starts, 0);
    check("basic_valids", valids, 4);
    check("basic_latency", lat, 1);
    check("basic_res", res_data, 64945);
    check("basic_iter", iter_done, 4);
`ifdef VDF_CHECKPOINT_EN
    check("basic_no_ckpt", ck_n, 0);
`endif
    consume("basic_idle");

    // T=0: no squaring, result is x the cycle after acceptance.
    send_job(16'd3, 64'd0, s, r);
    check("t0_no_start", s, 0);
    check("t0_rv_next", r, 1);
    check("t0_res", res_data, 3);
    consume("t0_idle");

    send_job(16'd3, 64'd1, s, r);
    wait_result(100, starts, valids, lat, got);
    check("t1_got", got, 1);
    check("t1_res", res_data, 9);
    consume("t1_idle");

    // Backpressure while the squarer keeps pulsing.
    send_job(16'd3, 64'd2, s, r);
    wait_result(100, starts, valids, lat, got);
    check("bp_got", got, 1);
    repeat (50) @(negedge clk);
    check("bp_res", res_data, 81);
    check("bp_iter", iter_done, 2);
    check("bp_ready", job_ready, 0);
    check("bp_rv", res_valid, 1);
    consume("bp_idle");
    check("bp_ready_after", job_ready, 1);
    send_job(16'd5, 64'd1, s, r);
    wait_result(100, starts, valids, lat, got);
    check("b2b_got", got, 1);
    check("b2b_res", res_data, 25);
    consume("b2b_idle");

    // Abort after the 2nd iteration.
    send_job(16'd3, 64'd4, s, r);
    wait_valids(2, 100, ok);
    check("abort_wait", ok, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rv", res_valid, 0);
    check("abort_iter", iter_done, 2);
    check("abort_ready", job_ready, 1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    // Abort coinciding with the final sq_valid.
    send_job(16'd3, 64'd4, s, r);
    wait_valids(4, 100, ok);
    check("abort4_wait", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort4_rv", res_valid, 0);
    check("abort4_busy", busy, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("abort4_no_result", seen, 0);

    // Asynchronous reset mid-run.
    send_job(16'd3, 64'd4, s, r);
    wait_valids(2, 100, ok);
    check("rst_wait", ok, 1);
    #2 rst_n = 1'b0;
    #1 reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", job_ready, 1);
    send_job(16'd7, 64'd1, s, r);
    wait_result(100, starts, valids, lat, got);
    check("midrst_got", got, 1);
    check("midrst_res", res_data, 49);
    consume("midrst_idle");

`ifdef VDF_CHECKPOINT_EN
    ckpt_interval = 64'd2;
    send_job(16'd3, 64'd4, s, r);
    wait_result(100, starts, valids, lat, got);
    check("ckpt_got", got, 1);
    check("ckpt_count", ck_n, 2);
    check("ckpt_data0", ck_data[0], 81);
    check("ckpt_data1", ck_data[1], 64945);
    check("ckpt_res", res_data, 64945);
    consume("ckpt_idle");
    ckpt_interval = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
